// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// The optional SEQ_TX_ABORT_EN feature is handled in the interface and top files.
package seq_tx_pkg;

   localparam int STATE_W = 2;

   // Pattern the downstream detector recognises.
   localparam logic [3:0] DEF_PAT = 4'b1100;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2,
      ST_DONE  = 2'd3
   } tx_state_t;

   // Width of a counter that must reach n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_1100_pattern_gen_if.sv
// Request/stream bundle between a controller (master) and the transmitter (slave).
// With SEQ_TX_ABORT_EN defined, the bundle also carries an abort request.
interface seq_1100_pattern_gen_if #(
   parameter int PAT_W = 4,
   parameter int REP_W = 8,
   parameter int GAP_W = 4
);

   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [REP_W-1:0] reps;
   logic [GAP_W-1:0] gap;
`ifdef SEQ_TX_ABORT_EN
   logic             abort;
`endif
   logic             ser_out;
   logic             ser_valid;
   logic             busy;
   logic             done;

   modport master (
`ifdef SEQ_TX_ABORT_EN
      output abort,
`endif
      output start, pattern, reps, gap,
      input  ser_out, ser_valid, busy, done
   );

   modport slave (
`ifdef SEQ_TX_ABORT_EN
      input  abort,
`endif
      input  start, pattern, reps, gap,
      output ser_out, ser_valid, busy, done
   );

endinterface

// File: rtl/seq_tx_shreg.sv
// Parallel-load, MSB-first left-shift register; zeros shift in from the LSB,
// so the MSB reads 0 once a pattern has been fully shifted out.
module seq_tx_shreg #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [PAT_W-1:0] i_data,
   output logic             o_msb
);

   logic [PAT_W-1:0] r_sh;
   logic [PAT_W-1:0] w_shift_in;

   genvar gi;
   generate
      for (gi = 0; gi < PAT_W; gi++) begin : g_shift_in
         if (gi == 0) begin : g_lsb
            assign w_shift_in[gi] = 1'b0;
         end else begin : g_upper
            assign w_shift_in[gi] = r_sh[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_sh <= '0;
      end else if (i_load) begin
         r_sh <= i_data;
      end else if (i_shift) begin
         r_sh <= w_shift_in;
      end
   end

   assign o_msb = r_sh[PAT_W-1];

endmodule

// File: rtl/seq_1100_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with
// optional idle gaps. Define SEQ_TX_ABORT_EN to add the abort request.
module seq_1100_pattern_gen
   import seq_tx_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int REP_W = 8,
   parameter int GAP_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   seq_1100_pattern_gen_if.slave  bus
);

   localparam int               CNT_W    = cnt_width(PAT_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

   tx_state_t        r_state;
   logic [PAT_W-1:0] r_pat;
   logic [REP_W-1:0] r_reps_left;
   logic [GAP_W-1:0] r_gap;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;

   logic             w_abort;
   logic             w_accept;
   logic             w_last_bit;
   logic             w_last_rep;
   logic             w_gap_end;
   logic             w_load;
   logic             w_shift;
   logic             w_ser;
   logic [PAT_W-1:0] w_load_data;

`ifdef SEQ_TX_ABORT_EN
   assign w_abort = bus.abort && (r_state == ST_SHIFT || r_state == ST_GAP);
`else
   assign w_abort = 1'b0;
`endif

   assign w_accept   = (r_state == ST_IDLE) && bus.start && (bus.reps != '0);
   assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);
   assign w_last_rep = (r_reps_left == REP_W'(1));
   assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == GAP_W'(1));

   // Reload on a new frame, on a gapless repeat, or when a gap expires.
   assign w_load = !w_abort &&
                   (w_accept ||
                    (w_last_bit && !w_last_rep && (r_gap == '0)) ||
                    w_gap_end);
   assign w_shift     = (r_state == ST_SHIFT) && !w_load && !w_abort;
   assign w_load_data = (r_state == ST_IDLE) ? bus.pattern : r_pat;

   seq_tx_shreg #(
      .PAT_W (PAT_W)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_abort),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_data),
      .o_msb   (w_ser)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_pat       <= '0;
         r_reps_left <= '0;
         r_gap       <= '0;
         r_gap_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_abort) begin
            r_valid   <= 1'b0;
            r_done    <= 1'b1;
            r_bit_cnt <= '0;
            r_state   <= ST_DONE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.start) begin
                     r_pat       <= bus.pattern;
                     r_reps_left <= bus.reps;
                     r_gap       <= bus.gap;
                     r_bit_cnt   <= '0;
                     r_busy      <= 1'b1;
                     if (w_accept) begin
                        r_valid <= 1'b1;
                        r_state <= ST_SHIFT;
                     end else begin
                        // Zero repetitions: report completion without sending bits.
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end
                  end
               end
               ST_SHIFT: begin
                  if (w_last_bit) begin
                     r_bit_cnt   <= '0;
                     r_reps_left <= r_reps_left - REP_W'(1);
                     if (w_last_rep) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                     end else if (r_gap != '0) begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= r_gap;
                        r_state   <= ST_GAP;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
               ST_GAP: begin
                  if (w_gap_end) begin
                     r_valid <= 1'b1;
                     r_state <= ST_SHIFT;
                  end else begin
                     r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                  end
               end
               ST_DONE: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.ser_out   = w_ser;
   assign bus.ser_valid = r_valid;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule

// File: tb/tb_seq_1100_pattern_gen.sv
// Scoreboard bench: the driver expands each accepted request into the expected
// per-cycle output stream; a negedge monitor pops and compares every cycle.
module tb_seq_1100_pattern_gen;
   import seq_tx_pkg::*;

   localparam int PAT_W = 4;
   localparam int REP_W = 8;
   localparam int GAP_W = 4;

   typedef struct {
      logic busy;
      logic valid;
      logic bitv;
      logic done;
      int   nbits;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   edge_n  = 0;
   int   free_at = 0;
   int   vcount  = 0;
   exp_t exp_q[$];

   seq_1100_pattern_gen_if #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) bus ();

   seq_1100_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output stream of one accepted request, from the frame rules.
   task automatic push_frame(input logic [PAT_W-1:0] p, input int r, input int g);
      logic b;
      if (r == 0) begin
         exp_q.push_back('{busy: 1'b1, valid: 1'b0, bitv: 1'b0, done: 1'b1, nbits: 0});
      end else begin
         for (int k = 0; k < r; k++) begin
            for (int i = PAT_W - 1; i >= 0; i--) begin
               b = p[i];
               exp_q.push_back('{busy: 1'b1, valid: 1'b1, bitv: b, done: 1'b0, nbits: -1});
            end
            if (k < r - 1) begin
               for (int j = 0; j < g; j++)
                  exp_q.push_back('{busy: 1'b1, valid: 1'b0, bitv: 1'b0, done: 1'b0, nbits: -1});
            end
         end
         exp_q.push_back('{busy: 1'b1, valid: 1'b0, bitv: 1'b0, done: 1'b1, nbits: r * PAT_W});
      end
      free_at = edge_n + exp_q.size() + 1;
   endtask

   // One clock: apply the reference model to what the DUT samples at this edge.
   task automatic tick();
      @(posedge clk);
      edge_n++;
      if (!rst) begin
         if (exp_q.size() > 0) $display("[TB] cyc %0d reset abandons frame", edge_n);
         exp_q.delete();
         free_at = edge_n + 1;
      end else begin
`ifdef SEQ_TX_ABORT_EN
         if (bus.abort && exp_q.size() > 0) begin
            $display("[TB] cyc %0d abort", edge_n);
            exp_q.delete();
            exp_q.push_back('{busy: 1'b1, valid: 1'b0, bitv: 1'b0, done: 1'b1, nbits: -1});
            free_at = edge_n + 2;
         end
`endif
         if (bus.start && edge_n >= free_at) begin
            $display("[TB] cyc %0d start pattern=%b reps=%0d gap=%0d",
                     edge_n, bus.pattern, bus.reps, bus.gap);
            push_frame(bus.pattern, int'(bus.reps), int'(bus.gap));
         end
      end
      #1;
   endtask

   task automatic launch(input logic [PAT_W-1:0] p, input int r, input int g);
      bus.pattern = p;
      bus.reps    = REP_W'(r);
      bus.gap     = GAP_W'(g);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (edge_n < free_at && guard < 5000) begin
         tick();
         guard++;
      end
      if (edge_n < free_at) begin
         n_fail++;
         $display("FAIL idle_timeout cyc=%0d got still_busy required idle", edge_n);
      end
      tick();
   endtask

   // Monitor: every cycle compare outputs with the next expected entry.
   initial begin
      exp_t e;
      logic [3:0] got;
      logic [3:0] want;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{busy: 1'b0, valid: 1'b0, bitv: 1'b0, done: 1'b0, nbits: -2};
         got  = {bus.busy, bus.ser_valid, bus.ser_out, bus.done};
         want = {e.busy, e.valid, e.bitv, e.done};
         n_tests++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got busy,valid,out,done=%b required %b",
                     edge_n, got, want);
         end
         if (bus.ser_valid === 1'b1) vcount++;
         if (e.done) begin
            if (e.nbits >= 0) begin
               n_tests++;
               if (vcount != e.nbits) begin
                  n_fail++;
                  $display("FAIL valid_count cyc=%0d got %0d required %0d",
                           edge_n, vcount, e.nbits);
               end
            end
            vcount = 0;
         end else if (e.nbits == -2) begin
            vcount = 0;
         end
      end
   end

   initial begin
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.pattern = '0;
      bus.reps    = '0;
      bus.gap     = '0;
`ifdef SEQ_TX_ABORT_EN
      bus.abort   = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b1;
      tick();

      launch(DEF_PAT, 2, 0);
      wait_idle();
      launch(DEF_PAT, 2, 3);
      wait_idle();
      launch(DEF_PAT, 0, 2);
      wait_idle();

      // Start mid-frame is ignored; the next request after completion is taken.
      launch(DEF_PAT, 2, 1);
      tick();
      tick();
      bus.pattern = 4'b1010;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      wait_idle();
      launch(4'b1010, 1, 0);
      wait_idle();

      // Reset while the third bit is on the line.
      launch(DEF_PAT, 3, 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      launch(4'b1001, 1, 0);
      wait_idle();

`ifdef SEQ_TX_ABORT_EN
      launch(DEF_PAT, 3, 4);
      for (int i = 0; i < PAT_W; i++) tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      wait_idle();
`endif

      launch(4'b0110, (1 << REP_W) - 1, 0);
      wait_idle();

      for (int i = 0; i < 2500; i++) begin
         rst         = ($urandom_range(0, 299) != 0);
         bus.start   = rst && ($urandom_range(0, 3) == 0);
         bus.pattern = PAT_W'($urandom);
         bus.reps    = REP_W'($urandom_range(0, 5));
         bus.gap     = GAP_W'($urandom_range(0, 3));
`ifdef SEQ_TX_ABORT_EN
         bus.abort   = rst && ($urandom_range(0, 29) == 0);
`endif
         tick();
      end
      rst       = 1'b1;
      bus.start = 1'b0;
`ifdef SEQ_TX_ABORT_EN
      bus.abort = 1'b0;
`endif
      wait_idle();
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_1100_pattern_gen.md
Name: seq_1100_pattern_gen

Overview:
Serial pattern transmitter that drives the stimulus side of the 1100 Moore sequence-detector link.
- On a start request it shifts a captured PAT_W-bit pattern out MSB-first, one bit per clock.
- Repeats the pattern a programmable number of times, with an optional idle gap between repetitions.
- Reports busy/done so a bench or controller can sequence frames into the detector's serial input.

Parameters:
PAT_W, 4, pattern width in bits (≥2)
REP_W, 8, width of repeat-count input
GAP_W, 4, width of inter-pattern gap-count input

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
start  in  1  request a transmission; sampled only in IDLE
pattern  in  PAT_W  pattern to send, MSB first; captured on accepted start
reps  in  REP_W  number of pattern repetitions; captured on accepted start
gap  in  GAP_W  idle cycles between repetitions; captured on accepted start
ser_out  out  1  serial data bit (feeds detector in_seq)
ser_valid  out  1  ser_out carries a pattern bit this cycle
busy  out  1  transmission in progress
done  out  1  one-cycle pulse after final bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset (rst=0 at a clk edge): state=IDLE; ser_out=0, ser_valid=0, busy=0, done=0; all internal registers cleared.
- All outputs are registered. Reset mid-operation abandons the frame; outputs are 0 from the next edge.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 with reps≠0: capture pattern/reps/gap, load the shift register, go to SHIFT. ser_out=pattern[PAT_W-1], ser_valid=1 and busy=1 become visible after that same edge (1-cycle latency).
  - start=1 with reps=0: go directly to DONE. busy=1, done=1 for one cycle, no valid bits.
- SHIFT:
  - Each cycle presents the next bit MSB-first, ser_valid=1.
  - A bit counter counts 0..PAT_W-1.
  - After the last bit, decrement the remaining-reps count:
    - remaining=0: go to DONE.
    - else if gap≠0: go to GAP.
    - else reload the captured pattern and continue SHIFT with no bubble. Back-to-back repetitions are contiguous.
- GAP: ser_out=0, ser_valid=0 for exactly gap cycles. Then reload the pattern and return to SHIFT.
- DONE: done=1, busy=1, ser_valid=0, ser_out=0 for one cycle, then IDLE with busy=0, done=0.
- start is ignored in SHIFT/GAP/DONE (no queueing). A new start can be accepted in the first IDLE cycle after DONE.
- Inputs pattern/reps/gap may change freely while busy; only the captured copies are used.
- Totals per accepted start (reps=R≥1, gap=G):
  - valid cycles = R·PAT_W
  - frame duration = R·PAT_W + (R−1)·G cycles
  - done asserts the cycle after the last valid bit
- reps counter is REP_W wide and does not wrap: the maximum 2^REP_W−1 repetitions is sent exactly.

Optional Feature:
SEQ_TX_ABORT_EN
- Defined: adds input port abort (1 bit).
- abort=1 in SHIFT or GAP: go to DONE at the next edge. ser_valid drops the same edge; done pulses one cycle, as on normal completion.
- abort in IDLE/DONE: ignored. abort and start together in IDLE: start wins.
- Undefined: no abort port; a frame always runs to completion.

Decomposition:
- Package seq_tx_pkg:
  - state enum (IDLE, SHIFT, GAP, DONE)
  - default-pattern constant DEF_PAT = 4'b1100
  - encoding width constant
- Sub-module seq_tx_shreg: parallel-load, MSB-first left-shift register with load/shift enables, parameterized by PAT_W. The FSM, bit counter, rep counter and gap counter stay in the top.

Test Plan:
- pattern=1100, reps=2, gap=0 → ser_valid high 8 consecutive cycles; ser_out = 1,1,0,0,1,1,0,0; done pulses cycle 9; busy high cycles 1–9.
- pattern=1100, reps=2, gap=3 → 1,1,0,0, then 3 cycles ser_valid=0, then 1,1,0,0; done on the next cycle; detector output asserts twice.
- reps=0 with start=1 → busy=1 and done=1 for exactly one cycle, ser_valid never asserts.
- start pulsed again mid-frame with pattern=1010 → ignored; the original 1100 stream is unchanged; the next start after DONE sends 1010.
- rst=0 during the 3rd bit → next edge all outputs 0, state IDLE; the following start transmits a fresh frame from the MSB.
- With SEQ_TX_ABORT_EN: abort during GAP of a reps=3 frame → ser_valid stays 0, done pulses next cycle, busy drops after it; no further bits sent.
